writeback_regfile: RTL

Write-back end of the execution-stage interface for the 16-bit processor: consumes the registered result triple (s2, wer, rdestrr) produced by the execution stage and commits it into a 16 × 16-bit register file. It supplies the two source operands (rdo1, s0) back to the execution stage and tracks in-flight destinations with a per-register pending scoreboard. Decode uses the scoreboard to raise a hazard stall. Same-cycle write-back is forwarded to the read ports.

---
 rtl/writeback_regfile.sv | 121 ++++++++++++
 1 files changed

// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
//
// Write-back end of the 16-bit processor's execution stage. Commits the
// registered result (s2, wer, rdestrr) into a 2**AW x DW register file,
// returns two source operands to the execution stage with same-cycle
// write-back forwarding, and keeps a per-register pending scoreboard that
// decode uses to raise a hazard stall.
//
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   s2         result from execution stage
//   wer        write enable from execution stage
//   rdestrr    destination register from execution stage
//   ra1, ra2   source read addresses from decode
//   issue      decode issues an instruction that will write issue_rd
//   issue_rd   destination of the issued instruction
//   rdo1, s0   source-1 / source-2 operands (combinational, bypassed)
//   hazard     a source of the current decode read is still pending
//   pending    scoreboard, bit i = register i awaiting write-back
//   wb_count   number of committed writes, wraps silently
// ---------------------------------------------------------------------------
module writeback_regfile #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     s2,
    input  logic              wer,
    input  logic [AW-1:0]     rdestrr,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    input  logic              issue,
    input  logic [AW-1:0]     issue_rd,
    output logic [DW-1:0]     rdo1,
    output logic [DW-1:0]     s0,
    output logic              hazard,
    output logic [2**AW-1:0]  pending,
    output logic [15:0]       wb_count
);

    localparam int NR = 2**AW;

    logic [DW-1:0] regs_q [NR];
    logic [DW-1:0] regs_d [NR];
    logic [NR-1:0] pending_q, pending_d;
    logic [15:0]   wb_count_q, wb_count_d;

    logic commit;
    logic byp1, byp2;

    // Writes to r0 are discarded entirely: no commit, no count, no retire.
    assign commit = wer && (rdestrr != '0);

    // A source matching the write in flight this cycle is forwarded, which
    // also hides its pending bit from the stall logic.
    assign byp1 = wer && (rdestrr == ra1);
    assign byp2 = wer && (rdestrr == ra2);

    // NOTE: every signal written in a combinational block is given a default
    // first, so no path through the block can leave it unassigned (latch).
    always_comb begin
        regs_d     = regs_q;
        pending_d  = pending_q;
        wb_count_d = wb_count_q;

        if (commit) begin
            regs_d[rdestrr]    = s2;
            pending_d[rdestrr] = 1'b0;
            wb_count_d         = wb_count_q + 16'd1;
        end

        // Applied after the retire so a same-cycle issue to the same
        // register wins: the new producer is still outstanding.
        if (issue && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end

        pending_d[0] = 1'b0;
    end

    always_comb begin
        rdo1 = '0;
        if (ra1 != '0) begin
            rdo1 = byp1 ? s2 : regs_q[ra1];
        end
    end

    always_comb begin
        s0 = '0;
        if (ra2 != '0) begin
            s0 = byp2 ? s2 : regs_q[ra2];
        end
    end

    assign hazard = ((ra1 != '0) && pending_q[ra1] && !byp1) ||
                    ((ra2 != '0) && pending_q[ra2] && !byp2);

    // NOTE: the register array is cleared by reset because architectural
    // state must read as zero after reset, not power-up garbage.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= '0;
            end
            pending_q  <= '0;
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign pending  = pending_q;
    assign wb_count = wb_count_q;

endmodule
